// File: rtl/cpu_pkg.sv
// cpu_pkg: values shared across the core's pipeline stages.
//   XLEN             - architectural register / address width
//   NOP_BUBBLE       - word presented downstream when no instruction exists;
//                      identical to the IF/ID flush value so a bubble and a
//                      flushed slot are indistinguishable to decode
//   INSTR_BYTES      - fixed instruction size, the PC step per instruction
//   DEFAULT_RESET_PC - boot address used when a stage is not overridden
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_BUBBLE       = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: two-entry instruction-word FIFO sitting between the
// instruction memory response port and the IF/ID register.
//   clk, rst   - clock and asynchronous active-high reset
//   push       - write push_data at the tail this cycle
//   pop        - drop the head entry this cycle
//   flush      - discard all contents (wins over push and pop)
//   push_data  - word to store
//   head_data  - oldest stored word (stale when count is 0)
//   count      - number of valid entries, 0..2
module fetch_buffer
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] head_data,
    output logic [1:0]      count
);

    logic [XLEN-1:0] mem [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic            do_push;
    logic            do_pop;

    // A push into a full buffer is only accepted when the head leaves in
    // the same cycle, so count stays at 2 in that case.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch ahead of the IF/ID register.
// Owns the fetch PC, issues in-order requests to instruction memory,
// buffers up to two returned words and hands one instruction per cycle to
// IF/ID, honouring hazard stalls and EX redirects.
//   clk, rst                  - clock, asynchronous active-high reset
//   stall                     - IF/ID is holding; do not consume
//   redirect_valid/pc         - taken branch/jump target from EX
//   imem_req/addr/gnt         - request channel to instruction memory
//   imem_rvalid/rdata         - in-order response channel
//   instr_out/pc_out/instr_valid - instruction, its PC and its validity
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic            instr_valid
);

    localparam logic [2:0] BUF_LIMIT = 3'(BUF_DEPTH);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] deliver_pc;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] head_data;
    logic [1:0]      outstanding;
    logic [1:0]      outstanding_after;
    logic [1:0]      discard;
    logic [1:0]      count;
    logic [2:0]      slots_in_use;
    logic            empty;
    logic            pop;
    logic            grant;
    logic            resp;
    logic            push;

    assign redirect_target = redirect_pc & ~32'h3;
    assign empty           = (count == 2'd0);
    assign pop             = !empty && !stall && !redirect_valid;

    // Every granted request has a reserved buffer slot, so the buffer can
    // never overflow: only issue while words in flight plus words held
    // (less the one leaving this cycle) leave a free slot.
    assign slots_in_use = {1'b0, outstanding} + {1'b0, count} - {2'b00, pop};
    assign imem_req     = !rst && !redirect_valid && (slots_in_use < BUF_LIMIT);
    assign imem_addr    = pc;
    assign grant        = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp              = imem_rvalid && (outstanding != 2'd0);
    assign push              = resp && (discard == 2'd0) && !redirect_valid;
    assign outstanding_after = outstanding - {1'b0, resp};

    // On redirect everything still in flight after this cycle is stale.
    // Pending discards are already part of outstanding, so the new discard
    // count is simply the in-flight count once this cycle's response leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            deliver_pc  <= RESET_PC;
            outstanding <= 2'd0;
            discard     <= 2'd0;
        end else begin
            outstanding <= outstanding_after + {1'b0, grant};
            if (redirect_valid) begin
                pc         <= redirect_target;
                deliver_pc <= redirect_target;
                discard    <= outstanding_after;
            end else begin
                if (grant) begin
                    pc <= pc + INSTR_BYTES;
                end
                if (pop) begin
                    deliver_pc <= deliver_pc + INSTR_BYTES;
                end
                if (resp && (discard != 2'd0)) begin
                    discard <= discard - 2'd1;
                end
            end
        end
    end

    fetch_buffer u_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (imem_rdata),
        .head_data (head_data),
        .count     (count)
    );

    assign instr_valid = !empty && !redirect_valid;
    assign instr_out   = instr_valid ? head_data : NOP_BUBBLE;
    assign pc_out      = deliver_pc;

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        (({1'b0, outstanding} + {1'b0, count}) <= BUF_LIMIT));

endmodule
